// File: rtl/osc_mon_scan.sv
// osc_mon_scan -- multi-channel ring-oscillator frequency monitor.
//
// Scans N_CH asynchronous oscillator inputs one at a time. For each channel
// it waits 4 settle cycles, then counts rising edges for 2^GATE_W clk cycles.
// It publishes the count with its channel index and updates that channel's
// over-temperature warning flag.
//
// Optional feature (compile-time macro):
//   OSC_MON_HYST_EN  defined   : warn set below thr_lo, cleared above thr_hi,
//                                held in between (set wins).
//                    undefined : warn = (count < thr_lo), thr_hi ignored.
//
// Parameters:
//   N_CH    number of oscillator channels (>= 1)
//   CNT_W   edge counter / threshold width
//   GATE_W  gate window is 2^GATE_W clk cycles (GATE_W >= 2, the
//           settle phase reuses the gate counter)
//
// Ports:
//   clk, rst_n   system clock, async active-low reset
//   en           scan enable
//   osc_in       oscillator inputs, asynchronous to clk
//   thr_lo       warn-set threshold
//   thr_hi       warn-clear threshold (hysteresis build only)
//   count_out    last published edge count
//   count_ch     channel index of count_out
//   count_valid  one-cycle pulse marking a new count_out/count_ch
//   warn         per-channel warning flags
//   busy         high whenever the scanner is not idle
module osc_mon_scan #(
   parameter int N_CH   = 2,
   parameter int CNT_W  = 16,
   parameter int GATE_W = 12,
   localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic [N_CH-1:0]   osc_in,
   input  logic [CNT_W-1:0]  thr_lo,
   input  logic [CNT_W-1:0]  thr_hi,
   output logic [CNT_W-1:0]  count_out,
   output logic [CH_W-1:0]   count_ch,
   output logic              count_valid,
   output logic [N_CH-1:0]   warn,
   output logic              busy
);

   typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_COUNT, S_LATCH} state_t;

   localparam int SETTLE_CYC = 4;

   state_t             state_q, state_d;
   logic [N_CH-1:0]    sync1_q, sync1_d;
   logic [N_CH-1:0]    sync2_q, sync2_d;
   logic [N_CH-1:0]    hist_q, hist_d;
   logic [CH_W-1:0]    idx_q, idx_d;
   logic [GATE_W-1:0]  gate_q, gate_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [CNT_W-1:0]   count_out_q, count_out_d;
   logic [CH_W-1:0]    count_ch_q, count_ch_d;
   logic               valid_q, valid_d;
   logic [N_CH-1:0]    warn_q, warn_d;
   logic               busy_q, busy_d;

   logic [N_CH-1:0]    edge_vec;
   logic               sel_edge;
   logic [CNT_W-1:0]   cnt_inc;
   logic               warn_new;

`ifndef OSC_MON_HYST_EN
   // Clear threshold has no function without hysteresis.
   logic unused_thr_hi;
   assign unused_thr_hi = ^thr_hi;
`endif

   // All channels are synchronised continuously so a freshly selected
   // channel already has valid history; SETTLE only has to flush the mux.
   assign edge_vec = sync2_q & ~hist_q;
   assign sel_edge = edge_vec[idx_q];

   always_comb begin
      sync1_d     = osc_in;
      sync2_d     = sync1_q;
      hist_d      = sync2_q;
      state_d     = state_q;
      idx_d       = idx_q;
      gate_d      = gate_q;
      cnt_d       = cnt_q;
      count_out_d = count_out_q;
      count_ch_d  = count_ch_q;
      valid_d     = 1'b0;
      warn_d      = warn_q;

      // Saturating increment; the counter never wraps.
      cnt_inc = (sel_edge && (cnt_q != '1)) ? cnt_q + CNT_W'(1) : cnt_q;

`ifdef OSC_MON_HYST_EN
      if (cnt_inc < thr_lo)      warn_new = 1'b1;
      else if (cnt_inc > thr_hi) warn_new = 1'b0;
      else                       warn_new = warn_q[idx_q];
`else
      warn_new = (cnt_inc < thr_lo);
`endif

      unique case (state_q)
         S_IDLE: begin
            idx_d  = '0;
            gate_d = '0;
            cnt_d  = '0;
            if (en) state_d = S_SETTLE;
         end
         S_SETTLE: begin
            cnt_d = '0;
            if (!en) begin
               state_d = S_IDLE;
            end else if (gate_q == GATE_W'(SETTLE_CYC - 1)) begin
               gate_d  = '0;
               state_d = S_COUNT;
            end else begin
               gate_d = gate_q + GATE_W'(1);
            end
         end
         S_COUNT: begin
            if (!en) begin
               state_d = S_IDLE;
            end else begin
               cnt_d  = cnt_inc;
               gate_d = gate_q + GATE_W'(1);
               // Results are registered on entry to LATCH so that
               // count_out, count_ch and warn change with the pulse.
               if (gate_q == '1) begin
                  state_d        = S_LATCH;
                  valid_d        = 1'b1;
                  count_out_d    = cnt_inc;
                  count_ch_d     = idx_q;
                  warn_d[idx_q]  = warn_new;
               end
            end
         end
         S_LATCH: begin
            idx_d   = (idx_q == CH_W'(N_CH - 1)) ? '0 : idx_q + CH_W'(1);
            gate_d  = '0;
            cnt_d   = '0;
            state_d = en ? S_SETTLE : S_IDLE;
         end
      endcase

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         sync1_q     <= '0;
         sync2_q     <= '0;
         hist_q      <= '0;
         idx_q       <= '0;
         gate_q      <= '0;
         cnt_q       <= '0;
         count_out_q <= '0;
         count_ch_q  <= '0;
         valid_q     <= 1'b0;
         warn_q      <= '0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         sync1_q     <= sync1_d;
         sync2_q     <= sync2_d;
         hist_q      <= hist_d;
         idx_q       <= idx_d;
         gate_q      <= gate_d;
         cnt_q       <= cnt_d;
         count_out_q <= count_out_d;
         count_ch_q  <= count_ch_d;
         valid_q     <= valid_d;
         warn_q      <= warn_d;
         busy_q      <= busy_d;
      end
   end

   assign count_out   = count_out_q;
   assign count_ch    = count_ch_q;
   assign count_valid = valid_q;
   assign warn        = warn_q;
   assign busy        = busy_q;

endmodule

// File: tb/tb_osc_mon_scan.sv
// Testbench for osc_mon_scan.
// u_a: N_CH=2, CNT_W=8, GATE_W=4  -- basic count, spacing, abort, reset.
// u_b: N_CH=2, CNT_W=8, GATE_W=10 -- saturation and warn thresholds
//      (expected warn values follow OSC_MON_HYST_EN).
module tb_osc_mon_scan;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic       rst_n;
   logic [7:0] thr_lo, thr_hi;

   logic       en_a, osc_a0, tog_a;
   logic [1:0] osc_a;
   logic [7:0] cnt_a;
   logic       ch_a, cv_a, busy_a;
   logic [1:0] warn_a;
   assign osc_a = {1'b0, osc_a0};

   logic       en_b;
   logic [1:0] osc_b;
   logic [7:0] cnt_b;
   logic       ch_b, cv_b, busy_b;
   logic [1:0] warn_b;

   osc_mon_scan #(.N_CH(2), .CNT_W(8), .GATE_W(4)) u_a (
      .clk(clk), .rst_n(rst_n), .en(en_a), .osc_in(osc_a),
      .thr_lo(thr_lo), .thr_hi(thr_hi),
      .count_out(cnt_a), .count_ch(ch_a), .count_valid(cv_a),
      .warn(warn_a), .busy(busy_a));

   osc_mon_scan #(.N_CH(2), .CNT_W(8), .GATE_W(10)) u_b (
      .clk(clk), .rst_n(rst_n), .en(en_b), .osc_in(osc_b),
      .thr_lo(thr_lo), .thr_hi(thr_hi),
      .count_out(cnt_b), .count_ch(ch_b), .count_valid(cv_b),
      .warn(warn_b), .busy(busy_b));

   // Synchronous full-rate toggle for u_a channel 0.
   always @(posedge clk) if (tog_a) #1 osc_a0 = ~osc_a0;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Advance to just after edge t (no-op if already there).
   task automatic wait_cyc(input int t);
      while (cyc < t) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Scoreboard entries: expected publication and the cycle it must appear in.
   typedef struct {
      logic       ch;
      logic [7:0] cnt;
      logic [1:0] warn;
      int         cyc;
   } exp_t;

   function automatic exp_t mk(input logic ch, input logic [7:0] cnt,
                               input logic [1:0] warn, input int c);
      exp_t e;
      e.ch = ch; e.cnt = cnt; e.warn = warn; e.cyc = c;
      return e;
   endfunction

   exp_t q_a[$];
   exp_t q_b[$];
   exp_t ea, eb;

   always @(negedge clk) begin
      if (rst_n && cv_a) begin
         if (q_a.size() == 0) chk("a_spurious_valid", 32'(cv_a), 32'd0);
         else begin
            ea = q_a.pop_front();
            chk("a_ch",   32'(ch_a),   32'(ea.ch));
            chk("a_cnt",  32'(cnt_a),  32'(ea.cnt));
            chk("a_warn", 32'(warn_a), 32'(ea.warn));
            chk("a_cyc",  32'(cyc),    32'(ea.cyc));
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && cv_b) begin
         if (q_b.size() == 0) chk("b_spurious_valid", 32'(cv_b), 32'd0);
         else begin
            eb = q_b.pop_front();
            chk("b_ch",   32'(ch_b),   32'(eb.ch));
            chk("b_cnt",  32'(cnt_b),  32'(eb.cnt));
            chk("b_warn", 32'(warn_b), 32'(eb.warn));
            chk("b_cyc",  32'(cyc),    32'(eb.cyc));
         end
      end
   end

   // u_b measurement table; n = edges driven on ch0 (-1: toggle every clk).
   typedef struct {
      int         n;
      logic       ch;
      logic [7:0] cnt;
      logic [1:0] warn;
   } vec_t;

   vec_t tbl[9];

   initial begin
      int e0, e1, e2, e3, k;

      tbl[0] = '{n: -1, ch: 1'b0, cnt: 8'd255, warn: 2'b00};
      tbl[1] = '{n:  0, ch: 1'b1, cnt: 8'd0,   warn: 2'b10};
      tbl[2] = '{n:  3, ch: 1'b0, cnt: 8'd3,   warn: 2'b11};
      tbl[3] = '{n:  0, ch: 1'b1, cnt: 8'd0,   warn: 2'b11};
`ifdef OSC_MON_HYST_EN
      tbl[4] = '{n:  5, ch: 1'b0, cnt: 8'd5,   warn: 2'b11};
      tbl[5] = '{n:  0, ch: 1'b1, cnt: 8'd0,   warn: 2'b11};
`else
      tbl[4] = '{n:  5, ch: 1'b0, cnt: 8'd5,   warn: 2'b10};
      tbl[5] = '{n:  0, ch: 1'b1, cnt: 8'd0,   warn: 2'b10};
`endif
      tbl[6] = '{n:  7, ch: 1'b0, cnt: 8'd7,   warn: 2'b10};
      tbl[7] = '{n:  0, ch: 1'b1, cnt: 8'd0,   warn: 2'b10};
      tbl[8] = '{n:  5, ch: 1'b0, cnt: 8'd5,   warn: 2'b10};

      rst_n = 1'b0; en_a = 1'b0; en_b = 1'b0; osc_a0 = 1'b0; tog_a = 1'b0;
      osc_b = 2'b00; thr_lo = 8'd4; thr_hi = 8'd6;

      // Reset state
      step(3);
      chk("rst_a_cnt",  32'(cnt_a),  0);
      chk("rst_a_ch",   32'(ch_a),   0);
      chk("rst_a_vld",  32'(cv_a),   0);
      chk("rst_a_warn", 32'(warn_a), 0);
      chk("rst_a_busy", 32'(busy_a), 0);
      chk("rst_b_warn", 32'(warn_b), 0);
      chk("rst_b_busy", 32'(busy_b), 0);
      rst_n = 1'b1;

      // Continuous scan on u_a: ch0 8, ch1 0, ch0 8, 21 cycles apart.
      tog_a = 1'b1;
      step(5);
      e0 = cyc;
      q_a.push_back(mk(1'b0, 8'd8, 2'b00, e0 + 21));
      q_a.push_back(mk(1'b1, 8'd0, 2'b10, e0 + 42));
      q_a.push_back(mk(1'b0, 8'd8, 2'b10, e0 + 63));
      chk("a_busy_idle", 32'(busy_a), 0);
      en_a = 1'b1;
      step(1);
      chk("a_busy_rise", 32'(busy_a), 1);
      wait_cyc(e0 + 63);
      en_a = 1'b0;
      step(1);
      chk("a_busy_fall", 32'(busy_a), 0);
      chk("a_q_drained", 32'(q_a.size()), 0);

      // Abort during ch1 COUNT (cycle 10), then restart from channel 0.
      step(3);
      e1 = cyc;
      q_a.push_back(mk(1'b0, 8'd8, 2'b10, e1 + 21));
      en_a = 1'b1;
      wait_cyc(e1 + 35);
      chk("abort_busy_pre", 32'(busy_a), 1);
      en_a = 1'b0;
      step(1);
      chk("abort_busy_fall", 32'(busy_a), 0);
      chk("abort_cnt_held",  32'(cnt_a),  8);
      chk("abort_ch_held",   32'(ch_a),   0);
      chk("abort_warn_held", 32'(warn_a), 32'h2);
      step(30);
      chk("abort_idle_busy", 32'(busy_a), 0);
      chk("abort_idle_cnt",  32'(cnt_a),  8);
      e2 = cyc;
      q_a.push_back(mk(1'b0, 8'd8, 2'b10, e2 + 21));
      en_a = 1'b1;
      wait_cyc(e2 + 21);
      en_a = 1'b0;
      step(2);
      chk("restart_q_drained", 32'(q_a.size()), 0);

      // Table-driven run on u_b: saturation then threshold sequence.
      step(2);
      k = cyc + 1;
      for (int i = 0; i < 9; i++)
         q_b.push_back(mk(tbl[i].ch, tbl[i].cnt, tbl[i].warn, k + 1028 + i * 1029));
      en_b = 1'b1;
      for (int i = 0; i < 9; i++) begin
         wait_cyc(k + i * 1029);
         if (tbl[i].n < 0) begin
            repeat (1026) begin
               osc_b[0] = ~osc_b[0];
               step(1);
            end
         end else if (tbl[i].n > 0) begin
            step(100);
            repeat (tbl[i].n) begin
               osc_b[0] = 1'b1;
               step(1);
               osc_b[0] = 1'b0;
               step(1);
            end
         end
      end
      wait_cyc(k + 8 * 1029 + 1028);
      en_b = 1'b0;
      step(2);
      chk("b_q_drained", 32'(q_b.size()), 0);
      chk("b_busy_fall", 32'(busy_b), 0);

      // Asynchronous reset mid-COUNT on u_a.
      step(1);
      e3 = cyc;
      en_a = 1'b1;
      wait_cyc(e3 + 12);
      chk("pre_rst_busy", 32'(busy_a), 1);
      #3 rst_n = 1'b0;
      #1;
      chk("arst_cnt",  32'(cnt_a),  0);
      chk("arst_ch",   32'(ch_a),   0);
      chk("arst_vld",  32'(cv_a),   0);
      chk("arst_warn", 32'(warn_a), 0);
      chk("arst_busy", 32'(busy_a), 0);
      chk("arst_b_warn", 32'(warn_b), 0);
      en_a = 1'b0;
      step(2);
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         step(1);
         chk("post_rst_busy", 32'(busy_a), 0);
      end
      chk("post_rst_q", 32'(q_a.size()), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL timeout: simulation exceeded time limit");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
      $fatal(1);
   end

endmodule
